// File: rtl/approx_mult_pkg.sv
// Width helpers and the reference product for the split-field approximate multiplier.
// The approximate result drops only the low x low sub-product.
package approx_mult_pkg;

  localparam int REF_W = 32;

  function automatic int hi_w(input int width, input int split);
    return width - split;
  endfunction

  function automatic int prod_w(input int width);
    return 32'sd2 * width;
  endfunction

  function automatic int cross_w(input int width, input int split);
    return hi_w(width, split) + split + 32'sd1;
  endfunction

  // Operands up to REF_W bits; split selects the low-field width.
  function automatic logic [2*REF_W-1:0] ref_prod(input logic [REF_W-1:0] a,
                                                  input logic [REF_W-1:0] b,
                                                  input int split,
                                                  input logic approx);
    logic [REF_W-1:0]   mask;
    logic [2*REF_W-1:0] full;
    logic [2*REF_W-1:0] ll;
    mask = ~(32'hFFFF_FFFF << split);
    full = {{REF_W{1'b0}}, a} * {{REF_W{1'b0}}, b};
    ll   = {{REF_W{1'b0}}, a & mask} * {{REF_W{1'b0}}, b & mask};
    if (approx) begin
      return full - ll;
    end else begin
      return full;
    end
  endfunction

endpackage

// File: rtl/split_pp_gen.sv
// Splits both operands into high/low fields and forms the four sub-products.
module split_pp_gen
  import approx_mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int SPLIT = 3,
  localparam int H     = hi_w(WIDTH, SPLIT)
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_approx,
  output logic [2*H-1:0]     o_pp_hh,
  output logic [H+SPLIT-1:0] o_pp_hl,
  output logic [H+SPLIT-1:0] o_pp_lh,
  output logic [2*SPLIT-1:0] o_pp_ll
);

  logic [H-1:0]     w_a_h;
  logic [H-1:0]     w_b_h;
  logic [SPLIT-1:0] w_a_l;
  logic [SPLIT-1:0] w_b_l;

  assign w_a_h = i_a[WIDTH-1:SPLIT];
  assign w_b_h = i_b[WIDTH-1:SPLIT];
  assign w_a_l = i_a[SPLIT-1:0];
  assign w_b_l = i_b[SPLIT-1:0];

  // Operands are zero-extended to the product width so no carry is lost.
  always_comb begin
    o_pp_hh = {{H{1'b0}}, w_a_h} * {{H{1'b0}}, w_b_h};
    o_pp_hl = {{SPLIT{1'b0}}, w_a_h} * {{H{1'b0}}, w_b_l};
    o_pp_lh = {{H{1'b0}}, w_a_l} * {{SPLIT{1'b0}}, w_b_h};
    if (i_approx) begin
      o_pp_ll = {(2*SPLIT){1'b0}};
    end else begin
      o_pp_ll = {{SPLIT{1'b0}}, w_a_l} * {{SPLIT{1'b0}}, w_b_l};
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage elastic split multiplier: stage 1 holds sub-products, stage 2 the
// recombined product; each stage advances when its successor can take data.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SPLIT = 3,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_approx
);

  localparam int H  = hi_w(WIDTH, SPLIT);
  localparam int PW = prod_w(WIDTH);
  localparam int CW = cross_w(WIDTH, SPLIT);

  logic [2*H-1:0]     w_pp_hh;
  logic [H+SPLIT-1:0] w_pp_hl;
  logic [H+SPLIT-1:0] w_pp_lh;
  logic [2*SPLIT-1:0] w_pp_ll;
  logic [CW-1:0]      w_cross;
  logic [PW-1:0]      w_sum;
  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_in_xfer;

  logic               r_v1;
  logic [2*H-1:0]     r_pp_hh;
  logic [H+SPLIT-1:0] r_pp_hl;
  logic [H+SPLIT-1:0] r_pp_lh;
  logic [2*SPLIT-1:0] r_pp_ll;
  logic [TAG_W-1:0]   r_tag1;
  logic               r_approx1;
  logic               r_v2;
  logic [PW-1:0]      r_p;
  logic [TAG_W-1:0]   r_tag2;
  logic               r_approx2;

  split_pp_gen #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT)
  ) u_pp_gen (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_approx (in_approx),
    .o_pp_hh  (w_pp_hh),
    .o_pp_hl  (w_pp_hl),
    .o_pp_lh  (w_pp_lh),
    .o_pp_ll  (w_pp_ll)
  );

  // Ready depends only on occupancy and out_ready, never on in_valid.
  always_comb begin
    w_s2_adv  = ~r_v2 | out_ready;
    w_s1_adv  = ~r_v1 | w_s2_adv;
    w_in_xfer = in_valid & w_s1_adv;
  end

  assign in_ready = w_s1_adv;

  // Cross terms carry a guard bit so their sum cannot overflow before alignment.
  always_comb begin
    w_cross = {1'b0, r_pp_hl} + {1'b0, r_pp_lh};
    w_sum   = ({{(PW-2*H){1'b0}}, r_pp_hh} << (2*SPLIT))
            + ({{(PW-CW){1'b0}}, w_cross} << SPLIT)
            + {{(PW-2*SPLIT){1'b0}}, r_pp_ll};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_v1 <= in_valid;
    end
  end

  // Stage-1 payload is qualified by r_v1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_pp_hh   <= w_pp_hh;
      r_pp_hl   <= w_pp_hl;
      r_pp_lh   <= w_pp_lh;
      r_pp_ll   <= w_pp_ll;
      r_tag1    <= in_tag;
      r_approx1 <= in_approx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_p       <= {PW{1'b0}};
      r_tag2    <= {TAG_W{1'b0}};
      r_approx2 <= 1'b0;
    end else if (w_s2_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p       <= w_sum;
        r_tag2    <= r_tag1;
        r_approx2 <= r_approx1;
      end
    end
  end

  assign out_valid  = r_v2;
  assign out_p      = r_p;
  assign out_tag    = r_tag2;
  assign out_approx = r_approx2;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: four configurations run side by side, each with
// directed cases, back-pressure, mid-flight reset and a random sweep against a model.
module tb_approx_mult_pipe;

  localparam int NCFG  = 4;
  localparam int TAG_W = 4;
  localparam int NRAND = 2500;

  // Hand-computed approximate results per configuration (S = 3, 1, 7; W16/S5).
  localparam logic [63:0] AP_13_11   [NCFG] = '{64'd128,   64'd142,   64'd0,     64'd0};
  localparam logic [63:0] AP_255_255 [NCFG] = '{64'd64976, 64'd65024, 64'd48896, 64'd64064};
  localparam logic [63:0] AP_200_150 [NCFG] = '{64'd30000, 64'd30000, 64'd28416, 64'd29824};

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar G = 0; G < NCFG; G++) begin : g_cfg
    localparam int W = (G == 3) ? 16 : 8;
    localparam int S = (G == 0) ? 3 : (G == 1) ? 1 : (G == 2) ? 7 : 5;

    typedef struct {
      logic [63:0]      p;
      logic [TAG_W-1:0] tag;
      logic             ap;
      int               acc;
    } ent_t;

    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_approx;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;
    logic             out_approx;

    bit   fin = 1'b0;
    bit   armed = 1'b0;
    bit   prev_rst = 1'b0;
    ent_t q[$];

    approx_mult_pipe #(
      .WIDTH (W),
      .SPLIT (S),
      .TAG_W (TAG_W)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_approx  (in_approx),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_tag    (out_tag),
      .out_approx (out_approx)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d_%s", G, s);
    endfunction

    // Exact product, less the low-field product when approximating.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic ap);
      logic [63:0] lo_mask;
      lo_mask = (64'd1 << S) - 64'd1;
      return ap ? (a * b) - ((a & lo_mask) * (b & lo_mask)) : a * b;
    endfunction

    function automatic logic [W-1:0] rnd_op();
      int unsigned sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) return {W{1'b1}};
      else if (sel == 1) return W'($urandom_range(0, 15));
      else return W'($urandom);
    endfunction

    // Scoreboard: in-order queue of accepted ops; an op is visible two edges after acceptance.
    always @(negedge clk) begin : mon
      ent_t e;
      logic exp_v;
      if (armed) begin
        exp_v = (q.size() > 0) ? (q[0].acc + 1 <= cyc) : 1'b0;
        chk(nm("out_valid"), 64'(out_valid), 64'(exp_v));
        chk(nm("in_ready"), 64'(in_ready), 64'((q.size() < 2) || out_ready));
        if (prev_rst) begin
          chk(nm("rst_out_p"), 64'(out_p), 64'd0);
          chk(nm("rst_out_tag"), 64'(out_tag), 64'd0);
          chk(nm("rst_out_approx"), 64'(out_approx), 64'd0);
        end
        if (out_valid && q.size() > 0) begin
          chk(nm("out_p"), 64'(out_p), q[0].p);
          chk(nm("out_tag"), 64'(out_tag), 64'(q[0].tag));
          chk(nm("out_approx"), 64'(out_approx), 64'(q[0].ap));
        end
        if (rst) begin
          q.delete();
        end else begin
          if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
          if (in_valid && in_ready) begin
            e.p   = model(64'(in_a), 64'(in_b), in_approx);
            e.tag = in_tag;
            e.ap  = in_approx;
            e.acc = cyc + 1;
            q.push_back(e);
          end
        end
      end
      if (rst) armed <= 1'b1;
      prev_rst <= rst;
    end

    task automatic one_op(input logic [63:0] a, input logic [63:0] b, input logic ap,
                          input logic [TAG_W-1:0] tag, input logic [63:0] exp);
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a[W-1:0]; in_b = b[W-1:0]; in_approx = ap; in_tag = tag;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk(nm("lat1_valid"), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk(nm("lat2_valid"), 64'(out_valid), 64'd1);
      chk(nm("dir_p"), 64'(out_p), exp);
      chk(nm("dir_tag"), 64'(out_tag), 64'(tag));
    endtask

    task automatic backpressure();
      int sent;
      int got;
      sent = 0;
      got = 0;
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        out_ready = (k >= 4);
        in_valid  = (sent < 5);
        in_a      = rnd_op();
        in_b      = rnd_op();
        in_approx = 1'($urandom_range(0, 1));
        in_tag    = TAG_W'(sent);
        #1;
        if (k == 2 || k == 3) chk(nm("bp_in_ready"), 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          chk(nm("bp_order"), 64'(out_tag), 64'(got));
          got++;
        end
        if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      chk(nm("bp_count"), 64'(got), 64'd5);
    endtask

    task automatic rst_mid();
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op(); in_tag = 4'd9;
      @(posedge clk); #1;
      in_a = rnd_op(); in_tag = 4'd10;
      @(posedge clk); #1;
      chk(nm("full_in_ready"), 64'(in_ready), 64'd0);
      rst = 1'b1; out_ready = 1'b1; in_tag = 4'd11;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk(nm("rm_valid"), 64'(out_valid), 64'd0);
      chk(nm("rm_p"), 64'(out_p), 64'd0);
      chk(nm("rm_in_ready"), 64'(in_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk(nm("rm_stale"), 64'(out_valid), 64'd0);
      end
    endtask

    initial begin : drv
      int acc_n;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
      in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk(nm("reset_valid"), 64'(out_valid), 64'd0);
      chk(nm("reset_p"), 64'(out_p), 64'd0);
      chk(nm("reset_in_ready"), 64'(in_ready), 64'd1);

      chk(nm("pin_13_11_x"), model(64'd13, 64'd11, 1'b0), 64'd143);
      chk(nm("pin_13_11_a"), model(64'd13, 64'd11, 1'b1), AP_13_11[G]);
      chk(nm("pin_255_a"), model(64'd255, 64'd255, 1'b1), AP_255_255[G]);
      chk(nm("pin_200_a"), model(64'd200, 64'd150, 1'b1), AP_200_150[G]);

      one_op(64'd13,  64'd11,  1'b0, 4'd5, 64'd143);
      one_op(64'd13,  64'd11,  1'b1, 4'd5, AP_13_11[G]);
      one_op(64'd255, 64'd255, 1'b0, 4'd1, 64'd65025);
      one_op(64'd255, 64'd255, 1'b1, 4'd2, AP_255_255[G]);
      one_op(64'd200, 64'd150, 1'b0, 4'd3, 64'd30000);
      one_op(64'd200, 64'd150, 1'b1, 4'd4, AP_200_150[G]);
      backpressure();
      rst_mid();

      acc_n = 0;
      for (int c = 0; c < 20000 && acc_n < NRAND; c++) begin
        @(posedge clk); #1;
        rst       = ($urandom_range(0, 499) == 0);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_a      = rnd_op();
        in_b      = rnd_op();
        in_approx = 1'($urandom_range(0, 1));
        in_tag    = TAG_W'($urandom_range(0, 15));
        #1;
        if (!rst && in_valid && in_ready) acc_n++;
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk(nm("rand_count"), 64'(acc_n >= NRAND), 64'd1);
      chk(nm("drain_empty"), 64'(q.size()), 64'd0);
      chk(nm("drain_valid"), 64'(out_valid), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin : top
    bit all_fin;
    all_fin = 1'b0;
    for (int t = 0; t < 60000 && !all_fin; t++) begin
      @(posedge clk);
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;
    end
    chk("all_done", 64'(all_fin), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-bit split multipliers.
- Operands split at a configurable point into high/low fields; four sub-products are formed, then recombined by a cross-term adder and a final aligned adder.
- A per-transaction mode bit selects the exact result or an approximate result that omits the low×low sub-product.
- Sits between operand sources and accumulator logic behind a valid/ready stream interface, with two register stages.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- SPLIT, 3, width of the low field; 1 ≤ SPLIT ≤ WIDTH-1. High field width is H = WIDTH-SPLIT.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_approx  in  1  1 = approximate mode, 0 = exact.
- in_tag  in  TAG_W  user tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of this result.
- out_approx  out  1  mode used for this result.

Behaviour:
- Transfer rule: a transfer occurs on a cycle with valid&&ready; all arithmetic is unsigned.
- Field split:
  - A_H = A[WIDTH-1:SPLIT], A_L = A[SPLIT-1:0]; B likewise.
- Stage 1 (registered on input transfer):
  - PP_HH = A_H*B_H (2H bits).
  - PP_HL = A_H*B_L (H+SPLIT bits).
  - PP_LH = A_L*B_H (SPLIT+H bits).
  - PP_LL = A_L*B_L (2*SPLIT bits); PP_LL is forced to 0 when in_approx=1.
  - Tag and mode are registered alongside.
- Stage 2 (registered when stage 1 advances):
  - CROSS = PP_HL + PP_LH, width H+SPLIT+1, no carry lost.
  - out_p = (PP_HH << 2*SPLIT) + (CROSS << SPLIT) + PP_LL, truncated to 2*WIDTH. This never overflows, because the exact product < 2^(2*WIDTH).
  - Exact mode: out_p equals A*B for all inputs.
  - Approx mode: out_p = A*B - A_L*B_L.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid, with no stall.
  - Full throughput of 1 operation/cycle while out_ready=1.
- Handshake (per-stage elastic):
  - s2_adv = !v2 || out_ready.
  - s1_adv = !v1 || s2_adv.
  - in_ready = s1_adv. It is combinational from out_ready; there is no path from in_valid to in_ready.
- Data holding and ordering:
  - While out_valid=1 and out_ready=0, out_p, out_tag and out_approx hold stable. Stage 1 holds if occupied; a third input is refused (in_ready=0).
  - Results emerge strictly in input order. No operation is dropped or duplicated.
- Simultaneous events: on one cycle with an output transfer and an input transfer, both stages shift; occupancy is unchanged.
- Reset:
  - On rst: v1=v2=0, out_valid=0, out_p=0, out_tag=0, out_approx=0.
  - in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards in-flight operations with no partial output; rst takes priority over any transfer that cycle.
- Datapath registers are not required to be reset beyond the outputs listed above, but outputs must read 0 after reset.

Decomposition:
- Package approx_mult_pkg holds:
  - Localparam helpers for H, product width, cross width.
  - A function computing the reference approximate product for assertions.
- One sub-module, split_pp_gen (combinational), takes A, B and the approx bit and returns the four partial products. It is instantiated once, in front of the stage-1 registers.
- Stage registers and the handshake stay in approx_mult_pipe.

Test Plan:
- Exact mode, WIDTH=8, SPLIT=3:
  - A=13, B=11, approx=0, tag=5, out_ready=1 -> out_p=143, out_tag=5, out_valid exactly 2 cycles after transfer.
  - Same operands, approx=1 -> out_p=128 (LL=15 omitted).
- Extremes, WIDTH=8, SPLIT=3:
  - A=255, B=255: approx=0 -> 65025; approx=1 -> 64976.
  - A=200, B=150: both modes -> 30000 (A_L=0).
- Back-pressure: stream 5 ops with tags 0..4 while holding out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepted ops.
  - out_p is stable while stalled.
  - After release, tags emerge in order 0..4, one per cycle, none lost.
- Reset mid-flight: assert rst with both stages full -> next cycle out_valid=0, out_p=0, in_ready=1; no stale result ever appears.
- Random sweep over WIDTH=8/SPLIT∈{1,3,7} and WIDTH=16/SPLIT=5: 10k random ops with random in_valid/out_ready -> every result matches the package reference function, in order.
